// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, req/gnt/rvalid issue, prefetch FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        ready_i,
  input  logic        pc_v_x,
  input  logic [31:0] pc_x,
  output logic        inst_v_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc, resp_pc;
  logic [63:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] live_cnt, drop_cnt;
  logic          reset_q, halted;
  logic          grant, pop, resp_live, resp_drop, resp_any;
  logic [31:0]   redirect_pc;

  // Credits: FIFO room covers every live request, and total in-flight is bounded.
  assign imem_req_o  = !reset && !reset_q && !pc_v_x && !halted
                       && (int'(live_cnt) + int'(fifo_count) < FIFO_DEPTH)
                       && (int'(live_cnt) + int'(drop_cnt) < MAX_OUTSTANDING);
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;
  assign inst_v_o    = (fifo_count != '0) && !pc_v_x;
  assign pop         = inst_v_o && ready_i;
  assign resp_drop   = imem_rvalid_i && (drop_cnt != '0);
  assign resp_live   = imem_rvalid_i && (drop_cnt == '0) && (live_cnt != '0);
  assign resp_any    = resp_drop || resp_live;
  assign redirect_pc = pc_x & ~32'h3;
  assign {pc_o, inst_o} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && !pc_v_x && resp_live)
      fifo_mem[wr_ptr] <= {resp_pc, imem_rdata_i};
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      live_cnt   <= '0;
      drop_cnt   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted     <= 1'b0;
      fault_o    <= 1'b0;
      fault_pc_o <= '0;
`endif
    end else if (pc_v_x) begin
      // Everything still in flight becomes wrong-path; the response in this cycle is already discarded.
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      fetch_pc   <= redirect_pc;
      resp_pc    <= redirect_pc;
      live_cnt   <= '0;
      drop_cnt   <= drop_cnt + live_cnt - OW'(resp_any);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (pc_x[1:0] != 2'b00) begin
        halted     <= 1'b1;
        fault_o    <= 1'b1;
        fault_pc_o <= pc_x;
      end
`endif
    end else begin
      if (grant)
        fetch_pc <= fetch_pc + 32'd4;
      if (resp_drop)
        drop_cnt <= drop_cnt - OW'(1);
      if (resp_live) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      live_cnt   <= live_cnt + OW'(grant) - OW'(resp_live);
      fifo_count <= fifo_count + CW'(resp_live) - CW'(pop);
    end
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  assign halted     = 1'b0;
  assign fault_o    = 1'b0;
  assign fault_pc_o = '0;
`endif

  // A response with nothing outstanding is a memory protocol error; its data is ignored.
  always_ff @(posedge clk) begin
    if (!reset && imem_rvalid_i)
      assert (live_cnt != '0 || drop_cnt != '0);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with an in-order latency memory model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        ready_i;
  logic        pc_v_x;
  logic [31:0] pc_x;
  logic        inst_v_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;

  int          lat    = 1;
  bit          gnt_en = 1'b1;
  int          cyc    = 0;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];
  logic [31:0] gnt_log [$];
  logic [31:0] del_pc  [$];
  logic [31:0] del_inst[$];

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .ready_i      (ready_i),
    .pc_v_x       (pc_v_x),
    .pc_x         (pc_x),
    .inst_v_o     (inst_v_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .fault_o      (fault_o),
    .fault_pc_o   (fault_pc_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory and consumer model, acting mid-cycle once the stimulus for the cycle is settled.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      q_addr.delete();
      q_due.delete();
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end else begin
      imem_gnt_i = gnt_en;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_data(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
      if (imem_req_o && imem_gnt_i) begin
        q_addr.push_back(imem_addr_o);
        q_due.push_back(cyc + lat);
        gnt_log.push_back(imem_addr_o);
      end
      if (inst_v_o && ready_i) begin
        del_pc.push_back(pc_o);
        del_inst.push_back(inst_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle whose state was reset (reset input now low).
  task automatic do_reset(input int l, input bit g, input logic r);
    @(negedge clk);
    reset = 1'b1; pc_v_x = 1'b0; pc_x = '0;
    lat = l; gnt_en = g; ready_i = r;
    adv(2);
    gnt_log.delete(); del_pc.delete(); del_inst.delete();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ready_i = 1'b1; pc_v_x = 1'b0; pc_x = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

    // Sequential fetch, 1-cycle memory.
    do_reset(1, 1'b1, 1'b1); #2;
    chk("t1 reset req", imem_req_o, 0);
    chk("t1 reset inst_v", inst_v_o, 0);
    chk("t1 reset fault", fault_o, 0);
    chk("t1 reset fault_pc", fault_pc_o, 0);
    adv(1); #2;
    chk("t1 first req", imem_req_o, 1);
    chk("t1 first addr", imem_addr_o, 32'h0);
    adv(1); #2;
    chk("t1 inst_v early", inst_v_o, 0);
    chk("t1 second addr", imem_addr_o, 32'h4);
    adv(1); #2;
    chk("t1 inst_v first", inst_v_o, 1);
    chk("t1 pc first", pc_o, 32'h0);
    chk("t1 inst first", inst_o, mem_data(32'h0));
    adv(10); #2;
    chk("t1 gnt2", gnt_log[2], 32'h8);
    chk("t1 del pc1", del_pc[1], 32'h4);
    chk("t1 del pc2", del_pc[2], 32'h8);
    chk("t1 del inst2", del_inst[2], mem_data(32'h8));

    // Back-pressure: at most FIFO_DEPTH requests, then in-order drain.
    do_reset(1, 1'b1, 1'b0);
    adv(5); #2;
    chk("t2 grants stalled", gnt_log.size(), 2);
    chk("t2 none delivered", del_pc.size(), 0);
    adv(1); ready_i = 1'b1;
    adv(6); #2;
    chk("t2 del pc0", del_pc[0], 32'h0);
    chk("t2 del pc1", del_pc[1], 32'h4);
    chk("t2 del inst1", del_inst[1], mem_data(32'h4));
    chk("t2 del pc2", del_pc[2], 32'h8);

    // Redirect with two requests outstanding, 3-cycle memory.
    do_reset(3, 1'b1, 1'b1);
    adv(3); pc_v_x = 1'b1; pc_x = 32'h100; #2;
    chk("t3 redirect inst_v", inst_v_o, 0);
    chk("t3 redirect req", imem_req_o, 0);
    chk("t3 outstanding", gnt_log.size(), 2);
    adv(1); pc_v_x = 1'b0; #2;
    chk("t3 drop after redirect", dut.drop_cnt, 2);
    adv(10); #2;
    chk("t3 del pc0", del_pc[0], 32'h100);
    chk("t3 del inst0", del_inst[0], mem_data(32'h100));
    chk("t3 drop settled", dut.drop_cnt, 0);

    // Grant withheld for 4 cycles.
    do_reset(1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      adv(1); #2;
      chk("t4 held req", imem_req_o, 1);
      chk("t4 held addr", imem_addr_o, 32'h0);
      chk("t4 no inst_v", inst_v_o, 0);
    end
    adv(1); gnt_en = 1'b1;
    adv(4); #2;
    chk("t4 first gnt", gnt_log[0], 32'h0);
    chk("t4 del count", del_pc.size(), 2);
    chk("t4 del pc0", del_pc[0], 32'h0);
    chk("t4 del pc1", del_pc[1], 32'h4);

    // Back-to-back redirects, 3-cycle memory.
    do_reset(3, 1'b1, 1'b1);
    adv(3); pc_v_x = 1'b1; pc_x = 32'h200; #2;
    chk("t5 redirect1 req", imem_req_o, 0);
    adv(1); pc_x = 32'h300; #2;
    chk("t5 redirect2 inst_v", inst_v_o, 0);
    adv(1); pc_v_x = 1'b0; #2;
    chk("t5 drop mid", dut.drop_cnt, 1);
    chk("t5 new req", imem_req_o, 1);
    chk("t5 new addr", imem_addr_o, 32'h300);
    adv(10); #2;
    chk("t5 del pc0", del_pc[0], 32'h300);
    chk("t5 del pc1", del_pc[1], 32'h304);
    chk("t5 del inst0", del_inst[0], mem_data(32'h300));
    chk("t5 drop settled", dut.drop_cnt, 0);

    // Misaligned redirect target.
    do_reset(1, 1'b1, 1'b1);
    adv(2); pc_v_x = 1'b1; pc_x = 32'h102; #2;
    adv(1); pc_v_x = 1'b0; #2;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6 fault", fault_o, 1);
    chk("t6 fault_pc", fault_pc_o, 32'h102);
    chk("t6 req halted", imem_req_o, 0);
    adv(4); #2;
    chk("t6 req stays 0", imem_req_o, 0);
    chk("t6 no inst_v", inst_v_o, 0);
    chk("t6 grants", gnt_log.size(), 1);
    chk("t6 fault sticky", fault_o, 1);
`else
    chk("t6 req", imem_req_o, 1);
    chk("t6 aligned addr", imem_addr_o, 32'h100);
    chk("t6 no fault", fault_o, 0);
    chk("t6 no fault_pc", fault_pc_o, 0);
    adv(4); #2;
    chk("t6 del pc0", del_pc[0], 32'h100);
    chk("t6 del inst0", del_inst[0], mem_data(32'h100));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the execution stage.
- Holds the PC and issues sequential word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions in a small prefetch FIFO and presents them to execution as pc/inst/valid.
- Accepts a branch redirect (pc_v_x/pc_x) from execution, then flushes the wrong-path instructions it has buffered and the responses still in flight.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 2: prefetch FIFO entries (power of two, >=2).
- MAX_OUTSTANDING, 2: maximum issued-but-unanswered memory requests, live plus to-be-dropped.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch word address; [1:0] always 0
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses return in request order, latency >=1
- imem_rdata_i  in  32  instruction word
- ready_i  in  1  consumer accepts inst this cycle (tie 1 for the current execution stage)
- pc_v_x  in  1  redirect valid from execution
- pc_x  in  32  redirect target
- inst_v_o  out  1  instruction valid (drives inst_v_i)
- inst_o  out  32  instruction (drives inst_i)
- pc_o  out  32  PC of inst_o (drives pc_i)
- fault_o  out  1  misaligned-redirect fault (FETCH_MISALIGN_TRAP_EN only, else 0)
- fault_pc_o  out  32  offending target (FETCH_MISALIGN_TRAP_EN only, else 0)

Behaviour:
Reset state:
- fetch_pc = RESET_PC, resp_pc = RESET_PC.
- FIFO empty, live_cnt = 0, drop_cnt = 0.
- imem_req_o = 0, inst_v_o = 0, fault_o = 0, fault_pc_o = 0.
- Reset mid-operation discards everything. Responses to pre-reset requests are not tracked; the memory is reset with the block.

Issue:
- imem_req_o = !reset_q_cycle && !pc_v_x && !halted && (live_cnt + fifo_count < FIFO_DEPTH) && (live_cnt + drop_cnt < MAX_OUTSTANDING). The first request appears in the cycle after reset deasserts.
- imem_addr_o = fetch_pc.
- On req && gnt: fetch_pc += 4 (wraps mod 2^32) and live_cnt++.
- Memory does not require req stability; req may drop without a grant.

Response:
- When rvalid and drop_cnt > 0: drop_cnt-- and discard the data.
- Otherwise: push {resp_pc, rdata} into the FIFO, resp_pc += 4, live_cnt--.
- Pushed data is visible on the outputs the next cycle (no bypass).
- Credit accounting guarantees the FIFO never overflows. An rvalid with live_cnt = drop_cnt = 0 is a protocol error: assertion fires, data ignored.

Output:
- inst_v_o = !fifo_empty && !pc_v_x.
- inst_o/pc_o = FIFO head. When not valid, hold the head value (don't-care).
- Pop when inst_v_o && ready_i.

Redirect (pc_v_x = 1 in cycle t; the X-stage branch is not in the FIFO):
- In cycle t: inst_v_o forced 0 and no pop. imem_req_o forced 0.
- At the edge ending t: FIFO flushed; fetch_pc = resp_pc = {pc_x[31:2], 2'b00}.
- drop_cnt = drop_cnt + live_cnt - (rvalid_t ? 1 : 0), with the rvalid in t discarded. live_cnt = 0.
- First new-path request no earlier than t+1; first new-path inst_v_o no earlier than t+3 (1-cycle memory).
- Back-to-back redirects each apply in turn; drop accounting stays exact.

Simultaneous events:
- Push and pop in the same cycle are both allowed with a full FIFO only if pop occurs; credit prevents a push into a full FIFO.
- Grant and response in the same cycle: live_cnt is unchanged.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: a redirect with pc_x[1:0] != 0 sets halted, fault_o = 1, fault_pc_o = pc_x.
  - The FIFO is flushed, no further requests are issued, and in-flight responses are dropped.
  - Sticky until reset.
- Undefined: pc_x[1:0] is silently cleared; fault_o and fault_pc_o are tied 0.

Test Plan:
- Reset release, 1-cycle memory, ready_i = 1 -> addresses 0x0, 0x4, 0x8…; inst_v_o first high 2 cycles after the first grant, pc_o = 0x0, 0x4, 0x8 in order.
- ready_i held 0 for 5 cycles, 1-cycle memory -> at most FIFO_DEPTH = 2 requests issued; when ready_i returns, pc_o 0x0 then 0x4 with no loss or duplication.
- pc_v_x = 1 with pc_x = 0x100 while 2 requests are outstanding (3-cycle latency) -> both stale responses discarded, inst_v_o low in the redirect cycle, next delivered pc_o = 0x100 with the 0x100 data.
- imem_gnt_i low for 4 cycles, then high -> imem_addr_o unchanged until the grant, no inst_v_o pulses from ungranted requests.
- Redirects on consecutive cycles to 0x200 then 0x300 -> only 0x300-path instructions are delivered; drop_cnt returns to 0.
- (FETCH_MISALIGN_TRAP_EN) pc_x = 0x102 -> fault_o = 1 and fault_pc_o = 0x102 the next cycle, imem_req_o stays 0; without the macro, the fetch resumes at 0x100.
